trap_trigger_sequencer: RTL

- Generates the one-cycle trigger pulses consumed by the optical-trap DC toggle stage; its trig_o drives that stage's trig_i directly.
- Accepts a software trigger or an external asynchronous trigger and emits a burst of evenly spaced pulses.
- Enforces a holdoff window after each burst so that the downstream delay/toggle sequence is never retriggered mid-sequence.

---
 rtl/trap_trigger_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/trap_trigger_sequencer.sv
// ============================================================================
// Module   : trap_trigger_sequencer
// Function : Burst trigger generator for the optical-trap DC toggle stage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trap_trigger_sequencer #(
    parameter int COUNTER_WIDTH = 18,
    parameter int BURST_WIDTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     sw_trig_i,
    input  logic                     ext_trig_i,
    input  logic                     ext_trig_en_i,
    input  logic [BURST_WIDTH-1:0]   burst_count_i,
    input  logic [COUNTER_WIDTH-1:0] period_cycles_i,
    input  logic [COUNTER_WIDTH-1:0] holdoff_cycles_i,
    input  logic                     clear_i,
    output logic                     trig_o,
    output logic                     busy_o,
    output logic [BURST_WIDTH-1:0]   pulse_count_o,
    output logic                     missed_o
);

    localparam logic [COUNTER_WIDTH-1:0] c_cnt_zero  = '0;
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_one   = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_two   = COUNTER_WIDTH'(2);
    localparam logic [BURST_WIDTH-1:0]   c_burst_one = BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PERIOD  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Trigger capture
    // ------------------------------------------------------------------
    logic       r_ext_sync1;
    logic       r_ext_sync2;
    logic       r_ext_sync3;
    logic [1:0] r_ext_vld;
    logic       r_ext_armed;
    logic       r_sw_prev;

    // The armed flag only sets once a genuine low level has travelled through
    // the synchronizer, so a line held high across reset never fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ext_sync1 <= 1'b0;
            r_ext_sync2 <= 1'b0;
            r_ext_sync3 <= 1'b0;
            r_ext_vld   <= 2'b00;
            r_ext_armed <= 1'b0;
            r_sw_prev   <= 1'b0;
        end else begin
            r_ext_sync1 <= ext_trig_i;
            r_ext_sync2 <= r_ext_sync1;
            r_ext_sync3 <= r_ext_sync2;
            r_ext_vld   <= {r_ext_vld[0], 1'b1};
            r_ext_armed <= r_ext_armed | (r_ext_vld[1] & ~r_ext_sync2);
            r_sw_prev   <= sw_trig_i;
        end
    end

    logic w_ext_edge;
    logic w_sw_edge;
    logic w_start;

    assign w_ext_edge = r_ext_sync2 & ~r_ext_sync3 & r_ext_armed & ext_trig_en_i;
    assign w_sw_edge  = sw_trig_i & ~r_sw_prev;
    assign w_start    = w_sw_edge | w_ext_edge;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [BURST_WIDTH-1:0]   r_burst;
    logic [COUNTER_WIDTH-1:0] r_period_m1;
    logic [COUNTER_WIDTH-1:0] r_holdoff;
    logic [BURST_WIDTH-1:0]   r_pcnt;
    logic                     r_trig;
    logic                     r_busy;
    logic                     r_missed;

    state_t                   w_state_nxt;
    logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
    logic [BURST_WIDTH-1:0]   w_burst_nxt;
    logic [COUNTER_WIDTH-1:0] w_period_m1_nxt;
    logic [COUNTER_WIDTH-1:0] w_holdoff_nxt;
    logic [BURST_WIDTH-1:0]   w_pcnt_nxt;
    logic                     w_trig_nxt;
    logic                     w_miss;

    logic [BURST_WIDTH-1:0]   w_burst_eff;
    logic [COUNTER_WIDTH-1:0] w_period_eff;

    assign w_burst_eff  = (burst_count_i == '0) ? c_burst_one : burst_count_i;
    assign w_period_eff = (period_cycles_i < c_cnt_two) ? c_cnt_two : period_cycles_i;
    assign w_miss       = w_start & enable_i & (r_state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= c_cnt_zero;
            r_burst     <= c_burst_one;
            r_period_m1 <= c_cnt_one;
            r_holdoff   <= c_cnt_zero;
            r_pcnt      <= '0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_burst     <= w_burst_nxt;
            r_period_m1 <= w_period_m1_nxt;
            r_holdoff   <= w_holdoff_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_trig      <= w_trig_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_miss) begin
                r_missed <= 1'b1;
            end else if (clear_i) begin
                r_missed <= 1'b0;
            end
        end
    end

    // Holdoff is counted as H cycles from the expiry of the last period, so
    // the sequencer is back in IDLE exactly H cycles after that expiry.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_burst_nxt     = r_burst;
        w_period_m1_nxt = r_period_m1;
        w_holdoff_nxt   = r_holdoff;
        w_pcnt_nxt      = r_pcnt;
        w_trig_nxt      = 1'b0;

        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = c_cnt_zero;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_burst_nxt     = w_burst_eff;
                        w_period_m1_nxt = w_period_eff - c_cnt_one;
                        w_holdoff_nxt   = holdoff_cycles_i;
                        w_trig_nxt      = 1'b1;
                        w_pcnt_nxt      = c_burst_one;
                        w_cnt_nxt       = w_period_eff - c_cnt_one;
                        w_state_nxt     = ST_PERIOD;
                    end
                end

                ST_PERIOD: begin
                    if (r_cnt != c_cnt_zero) begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end else if (r_pcnt < r_burst) begin
                        w_trig_nxt = 1'b1;
                        w_pcnt_nxt = r_pcnt + c_burst_one;
                        w_cnt_nxt  = r_period_m1;
                    end else if (r_holdoff == c_cnt_zero) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_holdoff - c_cnt_one;
                        w_state_nxt = ST_HOLDOFF;
                    end
                end

                ST_HOLDOFF: begin
                    if (r_cnt != c_cnt_zero) begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = c_cnt_zero;
                end
            endcase
        end
    end

    assign trig_o        = r_trig;
    assign busy_o        = r_busy;
    assign pulse_count_o = r_pcnt;
    assign missed_o      = r_missed;

endmodule

`default_nettype wire
